// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of data_mem: one access per cycle, zero-latency grant,
// one-cycle read response routed back to the issuing port, bounded lock for atomic RMW.
module dmem_arbiter #(
   parameter int unsigned LOCK_MAX = 4,
   parameter bit          P0_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        p0_req,
   input  logic        p0_we,
   input  logic        p0_lock,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic [3:0]  p0_wstrb,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,

   input  logic        p1_req,
   input  logic        p1_we,
   input  logic        p1_lock,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic [3:0]  p1_wstrb,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,

   output logic        mem_re,
   output logic [31:0] mem_raddr,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata
);

   localparam logic [3:0] LockMax = 4'(LOCK_MAX);

   logic       last_q, last_d;
   logic       lock_act_q, lock_act_d;
   logic       owner_q, owner_d;
   logic [3:0] lock_cnt_q, lock_cnt_d;
   logic       rsp_v_q, rsp_v_d;
   logic       rsp_id_q, rsp_id_d;

   logic        gnt_any;
   logic        gnt_id;
   logic        owner_req;
   logic        sel_we;
   logic        sel_lock;
   logic [31:0] sel_addr;
   logic [3:0]  cnt_inc;

   assign owner_req = owner_q ? p1_req : p0_req;

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = 1'b0;
      if (!rst) begin
         if (lock_act_q && owner_req) begin
            gnt_any = 1'b1;
            gnt_id  = owner_q;
         end else if (p0_req && p1_req) begin
            gnt_any = 1'b1;
            gnt_id  = ~last_q;
         end else if (p0_req) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b0;
         end else if (p1_req) begin
            gnt_any = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   // With no grant gnt_id is 0, so the buses idle on port 0's values.
   assign sel_we    = gnt_id ? p1_we    : p0_we;
   assign sel_lock  = gnt_id ? p1_lock  : p0_lock;
   assign sel_addr  = gnt_id ? p1_addr  : p0_addr;
   assign mem_wdata = gnt_id ? p1_wdata : p0_wdata;
   assign mem_wstrb = gnt_id ? p1_wstrb : p0_wstrb;

   assign mem_raddr = sel_addr;
   assign mem_waddr = sel_addr;
   assign mem_re    = gnt_any && !sel_we;
   assign mem_we    = gnt_any && sel_we;

   assign p0_gnt = gnt_any && !gnt_id;
   assign p1_gnt = gnt_any && gnt_id;

   assign p0_rvalid = !rst && rsp_v_q && !rsp_id_q;
   assign p1_rvalid = !rst && rsp_v_q && rsp_id_q;
   assign p0_rdata  = mem_rdata;
   assign p1_rdata  = mem_rdata;

   // A lock survives only a locked grant whose run length stays below LOCK_MAX; any other
   // outcome (unlocked grant, owner idle, budget exhausted) releases it.
   always_comb begin
      last_d     = gnt_any ? gnt_id : last_q;
      cnt_inc    = (lock_act_q && (owner_q == gnt_id)) ? lock_cnt_q + 4'd1 : 4'd1;
      lock_act_d = 1'b0;
      lock_cnt_d = 4'd0;
      owner_d    = owner_q;
      if (gnt_any && sel_lock && (cnt_inc < LockMax)) begin
         lock_act_d = 1'b1;
         lock_cnt_d = cnt_inc;
         owner_d    = gnt_id;
      end
      rsp_v_d  = mem_re;
      rsp_id_d = gnt_id;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= P0_FIRST ? 1'b1 : 1'b0;
         lock_act_q <= 1'b0;
         owner_q    <= 1'b0;
         lock_cnt_q <= 4'd0;
         rsp_v_q    <= 1'b0;
         rsp_id_q   <= 1'b0;
      end else begin
         last_q     <= last_d;
         lock_act_q <= lock_act_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rsp_v_q    <= rsp_v_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a byte-enabled data_mem model
// (registered read, write committed at the clock edge).
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p0_lock;
   logic [31:0] p0_addr, p0_wdata;
   logic [3:0]  p0_wstrb;
   logic        p0_gnt, p0_rvalid;
   logic [31:0] p0_rdata;
   logic        p1_req, p1_we, p1_lock;
   logic [31:0] p1_addr, p1_wdata;
   logic [3:0]  p1_wstrb;
   logic        p1_gnt, p1_rvalid;
   logic [31:0] p1_rdata;
   logic        mem_re, mem_we;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.LOCK_MAX(4), .P0_FIRST(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_lock   (p0_lock),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_wstrb  (p0_wstrb),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_lock   (p1_lock),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_wstrb  (p1_wstrb),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .mem_re    (mem_re),
      .mem_raddr (mem_raddr),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata)
   );

   logic [31:0] mem [0:255];

   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem[mem_waddr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
      if (mem_re) mem_rdata <= mem[mem_raddr[9:2]];
   end

   // {req, we, lock}
   localparam logic [2:0] NO = 3'b000;
   localparam logic [2:0] RD = 3'b100;
   localparam logic [2:0] WR = 3'b110;
   localparam logic [2:0] RL = 3'b101;
   localparam logic [31:0] WA = 32'hAAAA0000;
   localparam logic [31:0] WB = 32'hBBBB0000;

   typedef struct {
      logic        rst;
      logic [2:0]  c0;
      logic [31:0] a0;
      logic [2:0]  c1;
      logic [31:0] a1;
      logic [31:0] d1;
      logic [3:0]  s1;
      logic [5:0]  exp;  // {p0_gnt, p1_gnt, mem_re, mem_we, p0_rvalid, p1_rvalid}
      logic [31:0] ea;
      logic [31:0] erd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [2:0] c0, input logic [31:0] a0,
                               input logic [2:0] c1, input logic [31:0] a1,
                               input logic [31:0] d1, input logic [3:0] s1,
                               input logic [5:0] exp, input logic [31:0] ea,
                               input logic [31:0] erd);
      vec_t v;
      v.rst = r;  v.c0 = c0;   v.a0 = a0; v.c1 = c1; v.a1 = a1;
      v.d1  = d1; v.s1 = s1;   v.exp = exp; v.ea = ea; v.erd = erd;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst      = v.rst;
      p0_req   = v.c0[2]; p0_we = v.c0[1]; p0_lock = v.c0[0];
      p0_addr  = v.a0;    p0_wdata = 32'h0; p0_wstrb = 4'h0;
      p1_req   = v.c1[2]; p1_we = v.c1[1]; p1_lock = v.c1[0];
      p1_addr  = v.a1;    p1_wdata = v.d1;  p1_wstrb = v.s1;
   endtask

   task automatic check_row(input int idx, input vec_t v);
      logic [5:0]  got;
      logic [31:0] addr;
      got = {p0_gnt, p1_gnt, mem_re, mem_we, p0_rvalid, p1_rvalid};
      n_chk++;
      if (got !== v.exp) begin
         n_fail++;
         $display("FAIL ctrl row %0d: got %b, want %b", idx, got, v.exp);
      end
      if (v.exp[3] || v.exp[2]) begin
         addr = v.exp[3] ? mem_raddr : mem_waddr;
         n_chk++;
         if (addr !== v.ea) begin
            n_fail++;
            $display("FAIL addr row %0d: got %h, want %h", idx, addr, v.ea);
         end
      end
      if (v.exp[1]) begin
         n_chk++;
         if (p0_rdata !== v.erd) begin
            n_fail++;
            $display("FAIL p0_rdata row %0d: got %h, want %h", idx, p0_rdata, v.erd);
         end
      end
      if (v.exp[0]) begin
         n_chk++;
         if (p1_rdata !== v.erd) begin
            n_fail++;
            $display("FAIL p1_rdata row %0d: got %h, want %h", idx, p1_rdata, v.erd);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] seq_pat;
      vec_t        v;
      logic [1:0]  got_g, exp_g;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h04] = WA;            // 0x10
      mem[8'h08] = WB;            // 0x20
      mem[8'h10] = 32'h11223344;  // 0x40

      // Reset, then continuous contention: alternate starting with p0.
      tbl.push_back(mk(1, RD, 32'h10, RD, 32'h20, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(1, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b101000, 32'h10, 0));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b101001, 32'h10, WB));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      // Idle: last must stay at p1, so next contention goes to p0.
      tbl.push_back(mk(0, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000001, 0, WB));
      tbl.push_back(mk(0, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b101000, 32'h10, 0));
      // Partial write then read-back on p1.
      tbl.push_back(mk(0, NO, 32'h10, WR, 32'h40, 32'hDEADBEEF, 4'b0011, 6'b010110, 32'h40, WA));
      tbl.push_back(mk(0, NO, 32'h10, RD, 32'h40, 0, 0, 6'b011000, 32'h40, 0));
      tbl.push_back(mk(0, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000001, 0, 32'h1122BEEF));
      // Lock: p0 gets 4, p1 gets 1, p0 gets 4 again.
      tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b101000, 32'h10, 0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b101010, 32'h10, WA));
      tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b101001, 32'h10, WB));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b101010, 32'h10, WA));
      tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      // Early release: p0 locks, drops lock on its 2nd grant, p1 wins next.
      tbl.push_back(mk(0, RL, 32'h10, RD, 32'h20, 0, 0, 6'b101001, 32'h10, WB));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b101010, 32'h10, WA));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      // Reset with p0's locked read in flight: no rvalid, no strobes.
      tbl.push_back(mk(0, RL, 32'h10, NO, 32'h20, 0, 0, 6'b101001, 32'h10, WB));
      tbl.push_back(mk(1, RL, 32'h10, RD, 32'h20, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000000, 0, 0));
      // Reset clears a p1 lock: afterwards contention goes to p0.
      tbl.push_back(mk(0, NO, 32'h10, RL, 32'h20, 0, 0, 6'b011000, 32'h20, 0));
      tbl.push_back(mk(1, RD, 32'h10, RL, 32'h20, 0, 0, 6'b000000, 0, 0));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b101000, 32'h10, 0));
      tbl.push_back(mk(0, RD, 32'h10, RD, 32'h20, 0, 0, 6'b011010, 32'h20, WA));
      tbl.push_back(mk(0, NO, 32'h10, NO, 32'h20, 0, 0, 6'b000001, 0, WB));

      drive(mk(1, NO, 0, NO, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      foreach (tbl[i]) begin
         drive(tbl[i]);
         #4;
         check_row(i, tbl[i]);
         @(posedge clk); #1;
      end

      // p1 holds lock under contention: its run is capped at 4, p0 waits at most 4 cycles.
      seq_pat = 11'b01111011110;  // MSB first: 1 = p1 granted
      v = mk(0, RD, 32'h10, RL, 32'h20, 0, 0, 0, 0, 0);
      drive(v);
      for (int c = 0; c < 11; c++) begin
         #4;
         got_g = {p0_gnt, p1_gnt};
         exp_g = seq_pat[10-c] ? 2'b01 : 2'b10;
         n_chk++;
         if (got_g !== exp_g) begin
            n_fail++;
            $display("FAIL lock_seq cycle %0d: got %b, want %b", c, got_g, exp_g);
         end
         @(posedge clk); #1;
      end
      drive(mk(0, NO, 0, NO, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported-per-direction data memory between the pipeline's load/store unit (port 0) and a loader/debug master (port 1). It accepts at most one access per cycle, drives the data memory's read or write strobes, and returns read data one cycle later to the port that issued the read. Round-robin fairness is used, with a bounded lock for atomic read-modify-write sequences. It sits between the pipeline's memory stage and `data_mem`.

## Interface
Parameters:
- `LOCK_MAX`, 4: maximum consecutive grants a locked port may hold before a forced release (1..15).
- `P0_FIRST`, 1: port favoured on the first contended cycle after reset (1 = port 0, 0 = port 1).

Ports (x = 0, 1):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `px_req`  in  1  port x requests an access this cycle.
- `px_we`  in  1  1 = write, 0 = read.
- `px_lock`  in  1  port x asks to keep the grant on following cycles.
- `px_addr`  in  32  byte address.
- `px_wdata`  in  32  write data.
- `px_wstrb`  in  4  byte enables; ignored for reads.
- `px_gnt`  out  1  request accepted this cycle (combinational).
- `px_rvalid`  out  1  read data for port x is valid this cycle.
- `px_rdata`  out  32  read data (`mem_rdata` passthrough).
- `mem_re`, `mem_raddr[31:0]`  out  read port toward `data_mem`.
- `mem_we`, `mem_waddr[31:0]`, `mem_wdata[31:0]`, `mem_wstrb[3:0]`  out  write port toward `data_mem`.
- `mem_rdata`  in  32  `data_mem` read data, valid 1 cycle after `mem_re`.

## Operation
- Exactly one port is granted per cycle, or none. The granted port's request drives the memory:
  - Read: `mem_re`=1, `mem_we`=0, `mem_raddr`=addr.
  - Write: `mem_we`=1, `mem_re`=0, waddr/wdata/wstrb passed through.
- When no port is granted, `mem_re` and `mem_we` are 0. The address and data buses then carry port 0's values and are don't-care.
- Arbitration, in priority order:
  1. Lock active and owner's req=1: grant the owner.
  2. Only one req: grant it.
  3. Both req: grant the port opposite to `last` (the last-granted port register).
- `last` updates on every grant.
- Lock state is held in three registers: `lock_act`, `owner`, and a 4-bit `lock_cnt`.
  - **Set:** a granted port with lock=1 sets `lock_act` and `owner`. `lock_cnt` counts consecutive owner grants, and the first grant counts as 1.
  - **Release:** the lock releases in the cycle after any of these:
    - the owner is granted with lock=0;
    - the owner's req=0;
    - `lock_cnt` reaches `LOCK_MAX`.
  - **Forced release:** on a forced release, if the other port requests in the next cycle, it must win, because `last` = owner.
- Read response: a single-entry register pair `rsp_v` and `rsp_id` captures (read granted, port id). In the next cycle, `px_rvalid` = `rsp_v && rsp_id==x`.
- `px_rdata` = `mem_rdata` for both ports. It is meaningful only while `px_rvalid` is high.
- Writes produce no response; `gnt` is their completion.
- Read-after-write to the same word in consecutive cycles returns the new data, because `data_mem` commits the write at the edge before the read. Same-cycle read-write conflicts are impossible because only one access is issued per cycle.

## Timing
- Reset (`rst`=1 at an edge):
  - `rsp_v`=0, `lock_act`=0, `lock_cnt`=0.
  - `last` = port 1 if `P0_FIRST` else port 0.
- While `rst`=1, all `px_gnt`, `mem_re` and `mem_we` are forced 0.
- All `px_rvalid` are 0 in the cycle after the reset edge.
- A read in flight when reset asserts is discarded: no `rvalid`.
- Grant latency: 0 cycles. `px_gnt` is asserted in the same cycle as `px_req`. A requester holds req/addr/data until it sees gnt=1.
- Read latency: `px_rvalid` is asserted exactly 1 cycle after the granted read cycle. Back-to-back reads give `rvalid` on consecutive cycles.
- Throughput: 1 access per cycle, sustained.
- Under continuous contention with no lock, grants alternate 0,1,0,1…
- A locked port receives at most `LOCK_MAX` consecutive grants while the other port waits. The other port's worst-case wait is `LOCK_MAX` cycles.

## Test plan
- **Reset and contention:** reset, then p0 and p1 both read continuously (p0 addr 0x10, p1 addr 0x20, memory 0x10=0xAAAA0000, 0x20=0xBBBB0000).
  - Required: grants alternate starting with p0.
  - Each `rvalid` arrives 1 cycle after its gnt, with the correct word, on the correct port only.
- **Write then read:** p1 writes 0xDEADBEEF with wstrb 4'b0011 to 0x40 (old value 0x11223344). Next cycle, p1 reads 0x40.
  - Required: `p1_rvalid` with 0x1122BEEF.
- **Lock:** `LOCK_MAX`=4; p0 req+lock continuously while p1 reqs continuously.
  - Required: p0 is granted 4 consecutive cycles, then p1 gets 1 grant, then p0 gets 4 again.
- **Early lock release:** p0 drops lock after 2 grants while both keep requesting.
  - Required: p1 is granted on the next cycle.
- **Reset mid-read:** assert `rst` in the cycle p0's read is granted.
  - Required: no `p0_rvalid` follows, `mem_re`=0 during reset, and the lock is cleared.
- **Idle:** no requests.
  - Required: `mem_re`=`mem_we`=0, both `rvalid`=0, and `last` unchanged.
